serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/adder_pkg.sv | 17 +
 rtl/serial_adder_full_adder.sv | 24 ++
 rtl/serial_adder.sv | 148 ++++++++++++++
 tb/tb_serial_adder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the bit-serial adder:
//   state_t       - FSM state encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH - default operand/sum width in bits
// -----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage : adder_pkg

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit combinational full adder used as the datapath of serial_adder.
// Ports:
//   x, y  - addend bits
//   ci    - carry in
//   s     - sum bit
//   co    - carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p_s;

    assign p_s = x ^ y;
    assign s   = p_s ^ ci;
    assign co  = (x & y) | (ci & p_s);

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: computes a + b + cin one bit per clock, LSB first.
// A start accepted in IDLE loads the operands; WIDTH SHIFT cycles follow,
// then a single DONE cycle with done=1, then back to IDLE.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request a new addition (accepted only while ready=1)
//   a, b  - WIDTH-bit addends, sampled on the accepting edge
//   cin   - carry in, sampled with a and b
//   ready - high in IDLE only
//   done  - one-cycle pulse when sum/cout/ovf are valid
//   sum   - a + b + cin mod 2^WIDTH
//   cout  - carry out of the MSB
//   ovf   - two's-complement overflow flag
//
// Configuration macro:
//   SERIAL_ADDER_OVF_EN - when defined, ovf is computed as the carry into the
//                         MSB XOR the carry out of it; when undefined, ovf is
//                         tied to 0 and its flop is not built.
// -----------------------------------------------------------------------------
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ready_r;
    logic               done_r;
    logic               cout_r;
    logic               fa_s_s;
    logic               fa_co_s;
    logic               msb_s;

    // The bit being processed this cycle is the MSB once WIDTH-1 bits are done
    assign msb_s = (cnt_r == CNT_W'(WIDTH - 1));

    full_adder u_fa (
        .x  (a_sh_r[0]),
        .y  (b_sh_r[0]),
        .ci (carry_r),
        .s  (fa_s_s),
        .co (fa_co_s)
    );

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_r;

    // Overflow capture: carry into the MSB (carry_r) XOR carry out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if ((state_r == SHIFT) && msb_s) begin
            ovf_r <= carry_r ^ fa_co_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    // Control FSM and serial datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                        ready_r <= 1'b0;
                        state_r <= SHIFT;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the LSB
                    sum_r   <= {fa_s_s, sum_r[WIDTH-1:1]};
                    a_sh_r  <= a_sh_r >> 1;
                    b_sh_r  <= b_sh_r >> 1;
                    carry_r <= fa_co_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (msb_s) begin
                        cout_r  <= fa_co_s;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign cout  = cout_r;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=4). Expected results come from
// integer arithmetic on the operands; timing expectations are checked every
// cycle of every operation.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_pass  = 0;
    int n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain integer addition, signed interpretation for overflow
    task automatic model(input int ai, input int bi, input int ci,
                         output logic [W-1:0] s, output logic co, output logic ov);
        int total;
        int sa;
        int sb;
        int ss;
        total = ai + bi + ci;
        s     = W'(total % (1 << W));
        co    = (total >= (1 << W));
        sa    = (ai >= (1 << (W - 1))) ? ai - (1 << W) : ai;
        sb    = (bi >= (1 << (W - 1))) ? bi - (1 << W) : bi;
        ss    = sa + sb + ci;
`ifdef SERIAL_ADDER_OVF_EN
        ov    = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
`else
        ov    = 1'b0;
        if (ss == 0) ov = 1'b0;
`endif
    endtask

    // Caller is at a negedge with the DUT in IDLE. mode 0: quiet inputs,
    // mode 1: random input/start noise while busy, mode 2: 9+9 start two cycles in.
    // Returns at the negedge after the DUT is back in IDLE.
    task automatic do_op(input int ai, input int bi, input int ci, input int mode);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        model(ai, bi, ci, es, ec, eo);
        check("ready_before_start", ready, 32'd1);
        a     = W'(ai);
        b     = W'(bi);
        cin   = ci[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            if (k == W + 1) begin
                check("done_pulse",  done,  32'd1);
                check("ready_done",  ready, 32'd0);
                check("sum",         sum,   32'(es));
                check("cout",        cout,  32'(ec));
                check("ovf",         ovf,   32'(eo));
            end else if (k == W + 2) begin
                check("done_clear",  done,  32'd0);
                check("ready_back",  ready, 32'd1);
                check("sum_hold",    sum,   32'(es));
                check("cout_hold",   cout,  32'(ec));
                check("ovf_hold",    ovf,   32'(eo));
            end else begin
                check("done_busy",   done,  32'd0);
                check("ready_busy",  ready, 32'd0);
            end
            start = 1'b0;
            if (mode == 1 && k <= W + 1) begin
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'($urandom);
                start = 1'($urandom_range(0, 1));
            end else if (mode == 2 && k == 2) begin
                a     = 4'd9;
                b     = 4'd9;
                cin   = 1'b0;
                start = 1'b1;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #1;
        check("rst_ready", ready, 32'd1);
        check("rst_done",  done,  32'd0);
        check("rst_sum",   sum,   32'd0);
        check("rst_cout",  cout,  32'd0);
        check("rst_ovf",   ovf,   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_op(3, 4, 0, 0);
        do_op(15, 1, 0, 0);
        do_op(7, 1, 0, 0);
        do_op(15, 15, 1, 0);
        do_op(2, 2, 0, 2);
        do_op(8, 8, 0, 1);

        // Reset two cycles into 5+6
        a     = 4'd5;
        b     = 4'd6;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", ready, 32'd1);
        check("abort_done",  done,  32'd0);
        check("abort_sum",   sum,   32'd0);
        check("abort_cout",  cout,  32'd0);
        check("abort_ovf",   ovf,   32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", done, 32'd0);
        end
        rst = 1'b0;
        do_op(5, 6, 0, 0);

        // Random operations, back to back
        for (int i = 0; i < 20; i++) begin
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 1)), i % 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_serial_adder
